lvdt_phase_ref_gen: RTL and testbench

LVDT_PHASE_REF_GEN -- requirements
Module: lvdt_phase_ref_gen

---
 rtl/lvdt_phase_ref_gen.sv | 89 ++++++++
 tb/tb_lvdt_phase_ref_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lvdt_phase_ref_gen.sv
// rtl/lvdt_phase_ref_gen.sv - LVDT excitation and phase-shifted demodulation reference generator
// Prescaled 256-step period counter drives excitation, demod reference and sampling strobes.
module lvdt_phase_ref_gen #(
  parameter int PRESCALE = 49
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] phase,
  input  logic       enable,
  output logic       exc_out,
  output logic       demod_ref,
  output logic       sample_strobe,
  output logic       period_start,
  output logic [7:0] phase_active
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [15:0] PRESCALE_W = 16'(PRESCALE);

  state_t      state, state_nxt;
  logic [15:0] presc, presc_nxt;
  logic [7:0]  cnt, cnt_nxt, pa_nxt, d_nxt;
  logic        exc_nxt, dref_nxt, ss_nxt, ps_nxt;
  logic        tick;

  assign tick = (presc == PRESCALE_W);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      presc         <= 16'd0;
      cnt           <= 8'd0;
      phase_active  <= 8'd0;
      exc_out       <= 1'b0;
      demod_ref     <= 1'b0;
      sample_strobe <= 1'b0;
      period_start  <= 1'b0;
    end else begin
      state         <= state_nxt;
      presc         <= presc_nxt;
      cnt           <= cnt_nxt;
      phase_active  <= pa_nxt;
      exc_out       <= exc_nxt;
      demod_ref     <= dref_nxt;
      sample_strobe <= ss_nxt;
      period_start  <= ps_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)  state_nxt = RUN;
      RUN:     if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    presc_nxt = 16'd0;
    cnt_nxt   = 8'd0;
    pa_nxt    = phase_active;
    ps_nxt    = 1'b0;
    ss_nxt    = 1'b0;
    exc_nxt   = 1'b0;
    dref_nxt  = 1'b0;
    if (state == IDLE && state_nxt == RUN) begin
      pa_nxt = phase;
      ps_nxt = 1'b1;
    end else if (state == RUN && state_nxt == RUN) begin
      presc_nxt = tick ? 16'd0 : 16'(presc + 16'd1);
      cnt_nxt   = tick ? 8'(cnt + 8'd1) : cnt;
      // New phase is latched on the 255->0 edge so it governs the whole next period.
      if (tick && cnt == 8'hff) begin
        pa_nxt = phase;
        ps_nxt = 1'b1;
      end
    end
    d_nxt = 8'(cnt_nxt - pa_nxt);
    if (state_nxt == RUN) begin
      exc_nxt  = ~cnt_nxt[7];
      dref_nxt = ~d_nxt[7];
      // d of 64 or 192 marks the centre of a demod half-cycle; only real advances strobe.
      ss_nxt   = (state == RUN) && tick && (d_nxt[6:0] == 7'h40);
    end
  end

endmodule

// File: tb/tb_lvdt_phase_ref_gen.sv
// tb/tb_lvdt_phase_ref_gen.sv - scoreboard bench for lvdt_phase_ref_gen
// Stimulus queues expected strobe/period events; a monitor pops them as the DUTs emit them.
module tb_lvdt_phase_ref_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] ph0, ph1;
  logic       en0, en1;
  logic       exc0, dref0, ss0, ps0, exc1, dref1, ss1, ps1;
  logic [7:0] pa0, pa1;
  logic [11:0] out0, out1;

  typedef struct {
    int          cyc;
    logic [11:0] v;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  int   e_base, f_base;

  always #5 clk = ~clk;

  lvdt_phase_ref_gen #(.PRESCALE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .phase(ph0), .enable(en0),
    .exc_out(exc0), .demod_ref(dref0), .sample_strobe(ss0),
    .period_start(ps0), .phase_active(pa0)
  );

  lvdt_phase_ref_gen #(.PRESCALE(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .phase(ph1), .enable(en1),
    .exc_out(exc1), .demod_ref(dref1), .sample_strobe(ss1),
    .period_start(ps1), .phase_active(pa1)
  );

  assign out0 = {ps0, ss0, exc0, dref0, pa0};
  assign out1 = {ps1, ss1, exc1, dref1, pa1};

  function automatic logic [11:0] pk(input logic ps, input logic ss, input logic ex,
                                     input logic dr, input logic [7:0] pa);
    return {ps, ss, ex, dr, pa};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push0(input int c, input logic [11:0] val);
    q0.push_back('{cyc: c, v: val});
  endtask

  task automatic push1(input int c, input logic [11:0] val);
    q1.push_back('{cyc: c, v: val});
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (ps0 || ss0) begin
      if (q0.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dut0 unexpected event: got %0h expected none (cycle %0d)", out0, cyc);
      end else begin
        e0 = q0.pop_front();
        chk("dut0 event cycle", cyc, e0.cyc);
        chk("dut0 event outputs", out0, e0.v);
      end
    end
    if (ps1 || ss1) begin
      if (q1.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dut1 unexpected event: got %0h expected none (cycle %0d)", out1, cyc);
      end else begin
        e1 = q1.pop_front();
        chk("dut1 event cycle", cyc, e1.cyc);
        chk("dut1 event outputs", out1, e1.v);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    en0 = 1'b0;
    en1 = 1'b0;
    ph0 = 8'd0;
    ph1 = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset outputs dut0", out0, 0);
    chk("reset outputs dut1", out1, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle after reset release", out0, 0);

    // PRESCALE=3: cnt steps every 4 clk, 1024 clk per period
    en1 = 1'b1;
    f_base = cyc + 1;
    push1(f_base,        pk(1, 0, 1, 1, 0));
    push1(f_base + 256,  pk(0, 1, 1, 1, 0));
    push1(f_base + 768,  pk(0, 1, 0, 0, 0));
    push1(f_base + 1024, pk(1, 0, 1, 1, 0));
    wait_cyc(f_base + 1224);
    chk("p3 exc at cnt 50", exc1, 1);
    en1 = 1'b0;
    wait_cyc(f_base + 1225);
    chk("p3 outputs after disable", out1, 0);
    repeat (3) @(negedge clk);
    en1 = 1'b1;
    f_base = cyc + 1;
    push1(f_base,       pk(1, 0, 1, 1, 0));
    push1(f_base + 256, pk(0, 1, 1, 1, 0));
    wait_cyc(f_base + 400);
    en1 = 1'b0;
    wait_cyc(f_base + 402);
    chk("p3 idle after second run", out1, 0);

    // PRESCALE=0, phase 0 then 32 (changed mid-period)
    en0 = 1'b1;
    e_base = cyc + 1;
    push0(e_base,       pk(1, 0, 1, 1, 0));
    push0(e_base + 64,  pk(0, 1, 1, 1, 0));
    push0(e_base + 192, pk(0, 1, 0, 0, 0));
    wait_cyc(e_base + 10);
    ph0 = 8'd32;
    push0(e_base + 256,       pk(1, 0, 1, 0, 32));
    push0(e_base + 256 + 96,  pk(0, 1, 1, 1, 32));
    push0(e_base + 256 + 224, pk(0, 1, 0, 0, 32));
    wait_cyc(e_base + 100);
    chk("phase0 exc/dref at cnt 100", {exc0, dref0}, 2'b11);
    chk("phase_active held mid-period", pa0, 0);

    e_base += 256;
    wait_cyc(e_base + 31);  chk("ph32 dref cnt 31", dref0, 0);
    wait_cyc(e_base + 32);  chk("ph32 dref cnt 32", dref0, 1);
    wait_cyc(e_base + 100);
    ph0 = 8'd96;
    push0(e_base + 256,       pk(1, 0, 1, 0, 96));
    push0(e_base + 256 + 32,  pk(0, 1, 1, 0, 96));
    push0(e_base + 256 + 160, pk(0, 1, 0, 1, 96));
    wait_cyc(e_base + 159); chk("ph32 dref cnt 159", dref0, 1);
    wait_cyc(e_base + 160); chk("ph32 dref cnt 160", dref0, 0);
    wait_cyc(e_base + 200); chk("ph32 still active after write", pa0, 32);

    e_base += 256;
    wait_cyc(e_base + 95);  chk("ph96 dref cnt 95", dref0, 0);
    wait_cyc(e_base + 96);  chk("ph96 dref cnt 96", dref0, 1);
    wait_cyc(e_base + 100);
    ph0 = 8'd200;
    push0(e_base + 256,       pk(1, 0, 1, 1, 200));
    push0(e_base + 256 + 8,   pk(0, 1, 1, 1, 200));
    push0(e_base + 256 + 136, pk(0, 1, 0, 0, 200));

    e_base += 256;
    wait_cyc(e_base + 71);  chk("ph200 dref cnt 71", dref0, 1);
    wait_cyc(e_base + 72);  chk("ph200 dref cnt 72", dref0, 0);
    wait_cyc(e_base + 199); chk("ph200 dref cnt 199", dref0, 0);
    wait_cyc(e_base + 200); chk("ph200 dref/exc cnt 200", {exc0, dref0}, 2'b01);
    // phase written on the load cycle itself must be captured
    wait_cyc(e_base + 255);
    ph0 = 8'd16;
    push0(e_base + 256, pk(1, 0, 1, 0, 16));

    e_base += 256;
    wait_cyc(e_base + 50);
    chk("ph16 captured on load cycle", pa0, 16);
    en0 = 1'b0;
    wait_cyc(e_base + 51);
    chk("disable: outputs 0, phase held", out0, pk(0, 0, 0, 0, 16));

    repeat (4) @(negedge clk);
    ph0 = 8'd128;
    en0 = 1'b1;
    e_base = cyc + 1;
    push0(e_base,      pk(1, 0, 1, 0, 128));
    push0(e_base + 64, pk(0, 1, 1, 0, 128));
    wait_cyc(e_base + 100);
    chk("ph128 inverse of exc at cnt 100", {exc0, dref0}, 2'b10);
    #2;
    reset_n = 1'b0;
    en0 = 1'b0;
    #1;
    chk("async reset drops outputs", out0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("idle after mid-period reset", out0, 0);
    chk("dut0 events all seen", q0.size(), 0);
    chk("dut1 events all seen", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
